// File: rtl/sub_array_reorder_sequencer_pkg.sv
// Shared types and helpers for the array-conversion reorder blocks.
package array_ops_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    DRAIN_A = 2'd1,
    DRAIN_B = 2'd2
  } seq_state_e;

  // Counter width for a 0..n-1 index; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sub_array_reorder_sequencer_if.sv
// Serial element streams into and out of the reorder sequencer.
interface sub_array_reorder_sequencer_if #(
  parameter int unsigned BIT_WIDTH = 4
);
  logic [BIT_WIDTH-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/sub_array_reorder_sequencer_index_counter.sv
// 2-D nested index counter over rows row_lo..row_hi and columns 0..COLS-1.
module sub_block_index_counter
  import array_ops_pkg::*;
#(
  parameter int unsigned ROWS      = 8,
  parameter int unsigned COLS      = 8,
  parameter bit          ROW_INNER = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ld_i,
  input  logic [cnt_width(ROWS)-1:0]    ld_row_i,
  input  logic                          en_i,
  input  logic [cnt_width(ROWS)-1:0]    row_lo_i,
  input  logic [cnt_width(ROWS)-1:0]    row_hi_i,
  output logic [cnt_width(ROWS)-1:0]    r_o,
  output logic [cnt_width(COLS)-1:0]    c_o,
  output logic                          wrap_c
);

  localparam int unsigned RW = cnt_width(ROWS);
  localparam int unsigned CW = cnt_width(COLS);

  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic          row_end;
  logic          col_end;

  assign row_end = (r_q == row_hi_i);
  assign col_end = (c_q == CW'(COLS - 1));
  assign wrap_c  = en_i & row_end & col_end;
  assign r_o     = r_q;
  assign c_o     = c_q;

  // Next index: explicit load wins, otherwise step with the chosen inner loop.
  always_comb begin
    r_d = r_q;
    c_d = c_q;
    if (ld_i) begin
      r_d = ld_row_i;
      c_d = '0;
    end else if (en_i) begin
      if (ROW_INNER) begin
        if (row_end) begin
          r_d = row_lo_i;
          c_d = col_end ? '0 : c_q + CW'(1);
        end else begin
          r_d = r_q + RW'(1);
        end
      end else begin
        if (col_end) begin
          c_d = '0;
          r_d = row_end ? row_lo_i : r_q + RW'(1);
        end else begin
          c_d = c_q + CW'(1);
        end
      end
    end
  end

  // Index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      c_q <= '0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
    end
  end

endmodule

// File: rtl/sub_array_reorder_sequencer.sv
// Buffers a row-major ROWS x COLS frame and replays it in sub-row
// column-major slot order: rows below SUB_ROWS first, then the rest.
module sub_array_reorder_sequencer
  import array_ops_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 4,
  parameter int unsigned ROWS      = 8,
  parameter int unsigned COLS      = 8,
  parameter int unsigned SUB_ROWS  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  sub_array_reorder_sequencer_if.slave  bus,
  output logic                          busy
);

  localparam int unsigned RW = cnt_width(ROWS);
  localparam int unsigned CW = cnt_width(COLS);

  if (SUB_ROWS < 1 || SUB_ROWS > ROWS) begin : g_bad_sub_rows
    $error("SUB_ROWS must lie in 1..ROWS");
  end

  seq_state_e st_q, st_d;

  logic [BIT_WIDTH-1:0] frame_q [ROWS][COLS];

  logic [RW-1:0] ld_r;
  logic [CW-1:0] ld_c;
  logic [RW-1:0] dr_r;
  logic [CW-1:0] dr_c;
  logic [RW-1:0] dr_row_lo;
  logic [RW-1:0] dr_row_hi;
  logic [RW-1:0] dr_ld_row;
  logic          load_en;
  logic          load_wrap;
  logic          drain_en;
  logic          drain_wrap;
  logic          drain_at_end;

  logic                 in_ready_c;
  logic                 out_valid_c;
  logic                 out_last_c;
  logic [BIT_WIDTH-1:0] out_data_c;
  logic                 busy_c;

  assign load_en      = bus.in_valid & in_ready_c;
  assign drain_en     = out_valid_c & bus.out_ready;
  assign dr_row_lo    = (st_q == DRAIN_B) ? RW'(SUB_ROWS) : '0;
  assign dr_row_hi    = (st_q == DRAIN_B) ? RW'(ROWS - 1) : RW'(SUB_ROWS - 1);
  assign dr_ld_row    = (st_q == DRAIN_A && SUB_ROWS < ROWS) ? RW'(SUB_ROWS) : '0;
  assign drain_at_end = (dr_r == dr_row_hi) && (dr_c == CW'(COLS - 1));

  // Row-major write position for the incoming stream.
  sub_block_index_counter #(
    .ROWS(ROWS), .COLS(COLS), .ROW_INNER(1'b0)
  ) u_load_cnt (
    .clk(clk), .rst_n(rst_n),
    .ld_i(1'b0), .ld_row_i('0), .en_i(load_en),
    .row_lo_i('0), .row_hi_i(RW'(ROWS - 1)),
    .r_o(ld_r), .c_o(ld_c), .wrap_c(load_wrap)
  );

  // Column-major read position; reloaded at each sub-block boundary.
  sub_block_index_counter #(
    .ROWS(ROWS), .COLS(COLS), .ROW_INNER(1'b1)
  ) u_drain_cnt (
    .clk(clk), .rst_n(rst_n),
    .ld_i(drain_wrap), .ld_row_i(dr_ld_row), .en_i(drain_en),
    .row_lo_i(dr_row_lo), .row_hi_i(dr_row_hi),
    .r_o(dr_r), .c_o(dr_c), .wrap_c(drain_wrap)
  );

  // Next state and stream outputs, all derived from state, counters and buffer.
  always_comb begin
    st_d        = st_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    out_last_c  = 1'b0;
    out_data_c  = '0;
    busy_c      = 1'b1;
    case (st_q)
      LOAD: begin
        in_ready_c = 1'b1;
        busy_c     = (ld_r != '0) || (ld_c != '0);
        if (load_wrap) st_d = DRAIN_A;
      end
      DRAIN_A: begin
        out_valid_c = 1'b1;
        out_data_c  = frame_q[dr_r][dr_c];
        out_last_c  = (SUB_ROWS == ROWS) && drain_at_end;
        if (drain_wrap) st_d = (SUB_ROWS < ROWS) ? DRAIN_B : LOAD;
      end
      DRAIN_B: begin
        out_valid_c = 1'b1;
        out_data_c  = frame_q[dr_r][dr_c];
        out_last_c  = drain_at_end;
        if (drain_wrap) st_d = LOAD;
      end
      default: st_d = LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= LOAD;
    else        st_q <= st_d;
  end

  // Frame storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (load_en) frame_q[ld_r][ld_c] <= bus.in_data;
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_last  = out_last_c;
  assign bus.out_data  = out_data_c;
  assign busy          = busy_c;

endmodule

// File: tb/tb_sub_array_reorder_sequencer.sv
// Drives three sequencer configurations and checks replay order against
// a slot-to-element mapping computed from the flattening layout.
module tb_sub_array_reorder_sequencer;

  logic clk;
  logic rst_n [3];
  logic [7:0] drv_data [3];
  logic       drv_valid [3];
  logic       drv_ready [3];

  logic [7:0] o_data [3];
  logic       o_valid [3];
  logic       o_last [3];
  logic       o_iready [3];
  logic       o_busy [3];
  logic       busy_a, busy_b, busy_c;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  frame_vals [$];

  sub_array_reorder_sequencer_if #(.BIT_WIDTH(8)) if_a ();
  sub_array_reorder_sequencer_if #(.BIT_WIDTH(8)) if_b ();
  sub_array_reorder_sequencer_if #(.BIT_WIDTH(4)) if_c ();

  sub_array_reorder_sequencer #(.BIT_WIDTH(8), .ROWS(4), .COLS(3), .SUB_ROWS(2))
    dut_a (.clk(clk), .rst_n(rst_n[0]), .bus(if_a), .busy(busy_a));
  sub_array_reorder_sequencer #(.BIT_WIDTH(8), .ROWS(4), .COLS(3), .SUB_ROWS(4))
    dut_b (.clk(clk), .rst_n(rst_n[1]), .bus(if_b), .busy(busy_b));
  sub_array_reorder_sequencer #(.BIT_WIDTH(4), .ROWS(8), .COLS(8), .SUB_ROWS(4))
    dut_c (.clk(clk), .rst_n(rst_n[2]), .bus(if_c), .busy(busy_c));

  assign if_a.in_data   = drv_data[0];
  assign if_a.in_valid  = drv_valid[0];
  assign if_a.out_ready = drv_ready[0];
  assign if_b.in_data   = drv_data[1];
  assign if_b.in_valid  = drv_valid[1];
  assign if_b.out_ready = drv_ready[1];
  assign if_c.in_data   = drv_data[2][3:0];
  assign if_c.in_valid  = drv_valid[2];
  assign if_c.out_ready = drv_ready[2];

  assign o_data[0] = if_a.out_data;
  assign o_data[1] = if_b.out_data;
  assign o_data[2] = 8'(if_c.out_data);
  assign o_valid[0] = if_a.out_valid;
  assign o_valid[1] = if_b.out_valid;
  assign o_valid[2] = if_c.out_valid;
  assign o_last[0] = if_a.out_last;
  assign o_last[1] = if_b.out_last;
  assign o_last[2] = if_c.out_last;
  assign o_iready[0] = if_a.in_ready;
  assign o_iready[1] = if_b.in_ready;
  assign o_iready[2] = if_c.in_ready;
  assign o_busy[0] = busy_a;
  assign o_busy[1] = busy_b;
  assign o_busy[2] = busy_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rows_of(input int d);
    return (d == 2) ? 8 : 4;
  endfunction

  function automatic int cols_of(input int d);
    return (d == 2) ? 8 : 3;
  endfunction

  function automatic int sub_of(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic int mask_of(input int d);
    return (d == 2) ? 15 : 255;
  endfunction

  // Row-major element index carried by flat slot n.
  function automatic int exp_pos(input int d, input int n);
    int rr, cc, m, rows, cols, sub;
    rows = rows_of(d);
    cols = cols_of(d);
    sub  = sub_of(d);
    if (n < cols * sub) begin
      cc = n / sub;
      rr = n % sub;
    end else begin
      m  = n - cols * sub;
      cc = m / (rows - sub);
      rr = sub + m % (rows - sub);
    end
    return rr * cols + cc;
  endfunction

  task automatic fill_frame(input int d, input int base, input bit rnd);
    frame_vals.delete();
    for (int k = 0; k < rows_of(d) * cols_of(d); k++)
      frame_vals.push_back(rnd ? 8'($urandom & mask_of(d)) : 8'((base + k) & mask_of(d)));
  endtask

  task automatic load_frame(input int d, input int gap_pct);
    int idx, cyc, total;
    idx = 0;
    cyc = 0;
    total = rows_of(d) * cols_of(d);
    while (idx < total && cyc < 2000) begin
      @(negedge clk);
      chk("load_in_ready", 32'(o_iready[d]), 32'd1);
      chk("load_out_valid", 32'(o_valid[d]), 32'd0);
      chk("load_out_data_zero", 32'(o_data[d]), 32'd0);
      chk("load_busy", 32'(o_busy[d]), 32'(idx != 0));
      if (int'($urandom_range(99)) < gap_pct) begin
        drv_valid[d] = 1'b0;
        drv_data[d]  = 8'($urandom);
      end else begin
        drv_valid[d] = 1'b1;
        drv_data[d]  = frame_vals[idx];
        idx++;
      end
      cyc++;
    end
    if (idx < total) chk("load_timeout", 32'(idx), 32'(total));
  endtask

  // stall: 0 always ready, 1 ready pattern 1,0,0, 2 random.
  task automatic drain_frame(input int d, input int stall, input int stop_after);
    int n, cyc, total, target;
    bit rdy;
    n = 0;
    cyc = 0;
    total = rows_of(d) * cols_of(d);
    target = (stop_after < total) ? stop_after : total;
    while (n < target && cyc < 5000) begin
      @(negedge clk);
      drv_valid[d] = 1'b0;
      chk("drain_out_valid", 32'(o_valid[d]), 32'd1);
      chk("drain_in_ready", 32'(o_iready[d]), 32'd0);
      chk("drain_busy", 32'(o_busy[d]), 32'd1);
      chk("drain_data", 32'(o_data[d]), 32'(frame_vals[exp_pos(d, n)]));
      chk("drain_last", 32'(o_last[d]), 32'(n == total - 1));
      case (stall)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(1));
      endcase
      drv_ready[d] = rdy;
      if (rdy) n++;
      cyc++;
    end
    if (n < target) chk("drain_timeout", 32'(n), 32'(target));
    if (target == total) begin
      @(negedge clk);
      drv_ready[d] = 1'b0;
      chk("post_in_ready", 32'(o_iready[d]), 32'd1);
      chk("post_out_valid", 32'(o_valid[d]), 32'd0);
      chk("post_busy", 32'(o_busy[d]), 32'd0);
      chk("post_out_last", 32'(o_last[d]), 32'd0);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_n[d]     = 1'b0;
      drv_data[d]  = '0;
      drv_valid[d] = 1'b0;
      drv_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_in_ready", 32'(o_iready[d]), 32'd1);
      chk("rst_out_valid", 32'(o_valid[d]), 32'd0);
      chk("rst_out_last", 32'(o_last[d]), 32'd0);
      chk("rst_out_data", 32'(o_data[d]), 32'd0);
      chk("rst_busy", 32'(o_busy[d]), 32'd0);
      rst_n[d] = 1'b1;
    end

    // 4x3, two-row first block: streaming, then stalled consumer.
    fill_frame(0, 0, 1'b0);
    load_frame(0, 0);
    drain_frame(0, 0, 1000);
    load_frame(0, 0);
    drain_frame(0, 1, 1000);

    // Reset after five outputs, then a fresh frame must replay cleanly.
    load_frame(0, 0);
    drain_frame(0, 0, 5);
    @(negedge clk);
    drv_ready[0] = 1'b0;
    rst_n[0] = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(o_valid[0]), 32'd0);
    chk("midrst_in_ready", 32'(o_iready[0]), 32'd1);
    chk("midrst_busy", 32'(o_busy[0]), 32'd0);
    chk("midrst_out_data", 32'(o_data[0]), 32'd0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    fill_frame(0, 100, 1'b0);
    load_frame(0, 0);
    drain_frame(0, 0, 1000);

    // Random data, random input gaps and random consumer stalls.
    for (int it = 0; it < 3; it++) begin
      fill_frame(0, 0, 1'b1);
      load_frame(0, 40);
      drain_frame(0, 2, 1000);
    end

    // Single sub-block covering every row.
    fill_frame(1, 0, 1'b0);
    load_frame(1, 0);
    drain_frame(1, 0, 1000);
    for (int it = 0; it < 2; it++) begin
      fill_frame(1, 0, 1'b1);
      load_frame(1, 30);
      drain_frame(1, 2, 1000);
    end

    // Default geometry, element k carries k mod 16.
    fill_frame(2, 0, 1'b0);
    load_frame(2, 0);
    drain_frame(2, 0, 1000);
    for (int it = 0; it < 2; it++) begin
      fill_frame(2, 0, 1'b1);
      load_frame(2, 25);
      drain_frame(2, 2, 1000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
